// File: rtl/cpri_tx_pkg.sv
// Shared definitions for the CPRI TX read-side packetizer.
// State encoding and FIFO fill-level width helper.
package cpri_tx_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  // One bit wider than usedw so a full FIFO fits.
  function automatic int avail_w(input int numwords);
    return $clog2(numwords) + 1;
  endfunction

endpackage

// File: rtl/pkt_out_reg.sv
// One-entry output register for the packet stream.
// Carries data, SOP, EOP and sequence number.
module pkt_out_reg #(
  parameter int DW = 64,
  parameter int SW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_flush,
  input  logic [SW-1:0] i_flush_seq,
  input  logic          i_load,
  input  logic [DW-1:0] i_data,
  input  logic          i_sop,
  input  logic          i_eop,
  input  logic [SW-1:0] i_seq,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  output logic          o_sop,
  output logic          o_eop,
  output logic [SW-1:0] o_seq
);

  logic          r_valid;
  logic [DW-1:0] r_data;
  logic          r_sop;
  logic          r_eop;
  logic [SW-1:0] r_seq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
      r_seq   <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
      r_seq   <= i_flush_seq;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_sop   <= i_sop;
      r_eop   <= i_eop;
      r_seq   <= i_seq;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_sop   = r_sop;
  assign o_eop   = r_eop;
  assign o_seq   = r_seq;

endmodule

// File: rtl/fifo_pkt_reader.sv
// Read-side packetizer: waits for a whole packet in the
// show-ahead FIFO, then streams it out with SOP/EOP/seq.
module fifo_pkt_reader
  import cpri_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int NUMWORDS   = 256,
  parameter int PKT_LEN    = 16,
  parameter int GAP_CYCLES = 0,
  parameter int SEQ_WIDTH  = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic [DATA_WIDTH-1:0]       fifo_dout,
  input  logic                        fifo_empty,
  input  logic                        fifo_full,
  input  logic [$clog2(NUMWORDS)-1:0] fifo_usedw,
  output logic                        fifo_rd_en,
  output logic [DATA_WIDTH-1:0]       m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic                        m_sop,
  output logic                        m_eop,
  output logic [SEQ_WIDTH-1:0]        m_seq,
  output logic                        busy,
  output logic                        underflow_err
);

  localparam int AW = avail_w(NUMWORDS);
  localparam int CW = $clog2(PKT_LEN + 1);

  localparam logic [AW-1:0] NUM_FULL = AW'(NUMWORDS);
  localparam logic [AW-1:0] PKT_THR  = AW'(PKT_LEN);
  localparam logic [CW-1:0] LAST_IDX = CW'(PKT_LEN - 1);
  localparam logic [7:0]    GAP_LAST =
    (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
  localparam logic [1:0]    ST_POST  =
    (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;

  logic [1:0]           r_state;
  logic [CW-1:0]        r_word_cnt;
  logic [7:0]           r_gap_cnt;
  logic [SEQ_WIDTH-1:0] r_seq;
  logic                 r_sop_acc;
  logic                 r_underflow;

  logic [AW-1:0]        w_avail;
  logic                 w_free;
  logic                 w_pop;
  logic                 w_acc;
  logic                 w_eop_hs;
  logic                 w_last;
  logic                 w_seq_inc;
  logic [SEQ_WIDTH-1:0] w_seq_nxt;

  assign w_avail  = fifo_full ? NUM_FULL : {1'b0, fifo_usedw};
  assign w_free   = !m_valid || m_ready;
  assign w_pop    = (r_state == ST_BURST) && !fifo_empty
                    && w_free && !flush;
  assign w_acc    = m_valid && m_ready;
  assign w_eop_hs = w_acc && m_eop;
  assign w_last   = (r_word_cnt == LAST_IDX);

  // A flushed packet consumes its seq once its SOP went out.
  assign w_seq_inc = w_eop_hs
    || (flush && (r_sop_acc || (w_acc && m_sop)));
  assign w_seq_nxt = r_seq
    + {{(SEQ_WIDTH-1){1'b0}}, w_seq_inc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_word_cnt  <= '0;
      r_gap_cnt   <= '0;
      r_seq       <= '0;
      r_sop_acc   <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_seq <= w_seq_nxt;
      if ((r_state == ST_BURST) && fifo_empty
          && w_free && !flush)
        r_underflow <= 1'b1;
      if (flush || w_eop_hs)
        r_sop_acc <= 1'b0;
      else if (w_acc && m_sop)
        r_sop_acc <= 1'b1;
      if (flush) begin
        r_state    <= ST_IDLE;
        r_word_cnt <= '0;
        r_gap_cnt  <= '0;
      end else begin
        unique case (1'b1)
          (r_state == ST_IDLE): begin
            if (w_avail >= PKT_THR) begin
              r_state    <= ST_BURST;
              r_word_cnt <= '0;
            end
          end
          (r_state == ST_BURST): begin
            if (w_pop) begin
              r_word_cnt <= r_word_cnt + CW'(1);
              if (w_last)
                r_state <= ST_DRAIN;
            end
          end
          (r_state == ST_DRAIN): begin
            if (w_eop_hs) begin
              r_state   <= ST_POST;
              r_gap_cnt <= '0;
            end
          end
          default: begin
            if (r_gap_cnt == GAP_LAST) begin
              r_state   <= ST_IDLE;
              r_gap_cnt <= '0;
            end else begin
              r_gap_cnt <= r_gap_cnt + 8'd1;
            end
          end
        endcase
      end
    end
  end

  pkt_out_reg #(
    .DW(DATA_WIDTH),
    .SW(SEQ_WIDTH)
  ) u_out (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_flush    (flush),
    .i_flush_seq(w_seq_nxt),
    .i_load     (w_pop),
    .i_data     (fifo_dout),
    .i_sop      (r_word_cnt == '0),
    .i_eop      (w_last),
    .i_seq      (r_seq),
    .i_ready    (m_ready),
    .o_valid    (m_valid),
    .o_data     (m_data),
    .o_sop      (m_sop),
    .o_eop      (m_eop),
    .o_seq      (m_seq)
  );

  assign fifo_rd_en    = w_pop;
  assign busy          = (r_state != ST_IDLE) || m_valid;
  assign underflow_err = r_underflow;

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Bench for fifo_pkt_reader: show-ahead FIFO model plus
// a scoreboard of expected words filled as words are written.
module tb_fifo_pkt_reader;

  localparam int DW = 32;
  localparam int NW = 32;
  localparam int PL = 16;
  localparam int GC = 3;
  localparam int SW = 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
    logic [SW-1:0] seq;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic [DW-1:0] fifo_dout;
  logic          fifo_empty;
  logic          fifo_full;
  logic [4:0]    fifo_usedw;
  logic          fifo_rd_en;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_sop;
  logic          m_eop;
  logic [SW-1:0] m_seq;
  logic          busy;
  logic          underflow_err;

  logic          tb_wr;
  logic [DW-1:0] tb_wdata;
  logic          tb_sclr;
  logic [DW-1:0] f_mem [NW];
  logic [4:0]    f_rp;
  logic [4:0]    f_wp;
  logic [5:0]    f_cnt;
  logic          f_rd;

  exp_t          sb[$];
  int            n_chk;
  int            n_fail;
  int            hs_cnt;
  int            wr_left;
  int            wr_pos;
  logic [DW-1:0] wr_data;
  logic [SW-1:0] exp_seq_w;
  logic          mon_en;

  fifo_pkt_reader #(
    .DATA_WIDTH(DW),
    .NUMWORDS  (NW),
    .PKT_LEN   (PL),
    .GAP_CYCLES(GC),
    .SEQ_WIDTH (SW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .fifo_dout    (fifo_dout),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full),
    .fifo_usedw   (fifo_usedw),
    .fifo_rd_en   (fifo_rd_en),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_sop        (m_sop),
    .m_eop        (m_eop),
    .m_seq        (m_seq),
    .busy         (busy),
    .underflow_err(underflow_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Show-ahead FIFO; usedw wraps to 0 when full.
  assign f_rd       = fifo_rd_en && (f_cnt != 6'd0);
  assign fifo_dout  = f_mem[f_rp];
  assign fifo_empty = (f_cnt == 6'd0);
  assign fifo_full  = (f_cnt == 6'd32);
  assign fifo_usedw = f_cnt[4:0];

  always @(posedge clk) begin
    if (tb_sclr) begin
      f_rp  <= '0;
      f_wp  <= '0;
      f_cnt <= '0;
    end else begin
      if (tb_wr) begin
        f_mem[f_wp] <= tb_wdata;
        f_wp        <= f_wp + 5'd1;
      end
      if (f_rd)
        f_rp <= f_rp + 5'd1;
      f_cnt <= f_cnt + {5'd0, tb_wr} - {5'd0, f_rd};
    end
  end

  task automatic step();
    exp_t e;
    @(negedge clk);
    if (rst_n && mon_en && m_valid && m_ready) begin
      hs_cnt++;
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_extra: got data=%h, none expected",
                 m_data);
      end else begin
        e = sb.pop_front();
        if ({m_data, m_sop, m_eop, m_seq} !==
            {e.data, e.sop, e.eop, e.seq}) begin
          n_fail++;
          $display("FAIL sb_word: got %h/%b/%b/%0d need %h/%b/%b/%0d",
                   m_data, m_sop, m_eop, m_seq,
                   e.data, e.sop, e.eop, e.seq);
        end
      end
    end
    @(posedge clk);
    #1;
    if (wr_left > 0 && f_cnt < 6'd32 && !tb_sclr) begin
      tb_wr    = 1'b1;
      tb_wdata = wr_data;
      sb.push_back('{wr_data, wr_pos == 0,
                     wr_pos == PL - 1, exp_seq_w});
      wr_data++;
      wr_left--;
      if (wr_pos == PL - 1) begin
        wr_pos = 0;
        exp_seq_w++;
      end else begin
        wr_pos++;
      end
    end else begin
      tb_wr = 1'b0;
    end
  endtask

  task automatic wait_idle(input string nm);
    bit ok = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_idle: busy=%b need 0", nm, busy);
    end
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d words left, need 0",
               nm, sb.size());
    end
  endtask

  task automatic clear_fifo();
    wr_left = 0;
    tb_wr   = 1'b0;
    tb_sclr = 1'b1;
    step();
    tb_sclr = 1'b0;
    sb.delete();
    wr_pos  = 0;
  endtask

  task automatic wait_sop(input string nm);
    bit ok = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (m_valid && m_sop) begin
        ok = 1;
        break;
      end
    end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_sop: no SOP seen, m_valid=%b", nm, m_valid);
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    flush   = 1'b0;
    m_ready = 1'b1;
    tb_wr   = 1'b0;
    tb_sclr = 1'b1;
    mon_en  = 1'b0;
    for (int i = 0; i < 3; i++) step();
    n_chk++;
    if ({fifo_rd_en, m_valid, m_sop, m_eop, m_data, m_seq,
         busy, underflow_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outs: rd=%b v=%b d=%h seq=%0d busy=%b uf=%b need 0",
               fifo_rd_en, m_valid, m_data, m_seq, busy, underflow_err);
    end
    rst_n   = 1'b1;
    tb_sclr = 1'b0;
    step();
    step();
    n_chk++;
    if (busy !== 1'b0 || fifo_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: busy=%b rd=%b need 0 0",
               busy, fifo_rd_en);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_threshold();
    bit bad = 0;
    bit ok  = 0;
    wr_left = PL - 1;
    for (int i = 0; i < 25; i++) begin
      step();
      if (fifo_rd_en !== 1'b0 || busy !== 1'b0) bad = 1;
    end
    n_chk++;
    if (bad) begin
      n_fail++;
      $display("FAIL thr_15_words: rd=%b busy=%b need 0 0",
               fifo_rd_en, busy);
    end
    wr_left = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (fifo_usedw == 5'd16) begin
        ok = 1;
        break;
      end
    end
    n_chk++;
    if (!ok || fifo_rd_en !== 1'b0 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL thr_seen: ok=%b rd=%b v=%b need 1 0 0",
               ok, fifo_rd_en, m_valid);
    end
    step();
    n_chk++;
    if (fifo_rd_en !== 1'b1 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL thr_first_pop: rd=%b v=%b need 1 0",
               fifo_rd_en, m_valid);
    end
    step();
    n_chk++;
    if (m_valid !== 1'b1 || m_sop !== 1'b1 || m_seq !== 8'd0) begin
      n_fail++;
      $display("FAIL thr_sop_lat: v=%b sop=%b seq=%0d need 1 1 0",
               m_valid, m_sop, m_seq);
    end
    bad = 0;
    for (int k = 1; k < PL; k++) begin
      step();
      if (m_valid !== 1'b1 || m_sop !== 1'b0) bad = 1;
      if (k < PL - 1 && m_eop !== 1'b0) bad = 1;
    end
    n_chk++;
    if (bad || m_eop !== 1'b1) begin
      n_fail++;
      $display("FAIL thr_burst: bad=%b eop=%b need 0 1", bad, m_eop);
    end
    wait_idle("thr");
    n_chk++;
    if (underflow_err !== 1'b0) begin
      n_fail++;
      $display("FAIL thr_uf: underflow_err=%b need 0", underflow_err);
    end
  endtask

  task automatic test_backpressure();
    int   start = hs_cnt;
    bit   bad   = 0;
    bit   stall = 0;
    exp_t held;
    wr_left = PL;
    for (int i = 0; i < 200; i++) begin
      step();
      if (stall && ({m_valid, m_data, m_sop, m_eop, m_seq} !==
                    {1'b1, held.data, held.sop, held.eop, held.seq}))
        bad = 1;
      m_ready = ~m_ready;
      stall   = m_valid && !m_ready;
      held    = '{m_data, m_sop, m_eop, m_seq};
      if (hs_cnt - start >= PL) break;
    end
    m_ready = 1'b1;
    n_chk++;
    if (bad) begin
      n_fail++;
      $display("FAIL bp_stable: outputs moved while stalled");
    end
    n_chk++;
    if (hs_cnt - start != PL) begin
      n_fail++;
      $display("FAIL bp_count: %0d words accepted need %0d",
               hs_cnt - start, PL);
    end
    wait_idle("bp");
  endtask

  task automatic test_full();
    int start;
    bit ok = 0;
    flush   = 1'b1;
    wr_left = NW;
    for (int i = 0; i < 60; i++) begin
      step();
      if (fifo_full) begin
        ok = 1;
        break;
      end
    end
    n_chk++;
    if (!ok || fifo_rd_en !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL full_hold: ok=%b rd=%b busy=%b need 1 0 0",
               ok, fifo_rd_en, busy);
    end
    start = hs_cnt;
    flush = 1'b0;
    step();
    n_chk++;
    if (fifo_rd_en !== 1'b1) begin
      n_fail++;
      $display("FAIL full_start: rd=%b need 1 (usedw=%0d full=%b)",
               fifo_rd_en, fifo_usedw, fifo_full);
    end
    for (int i = 0; i < 200; i++) begin
      step();
      if (hs_cnt - start >= NW) break;
    end
    n_chk++;
    if (hs_cnt - start != NW) begin
      n_fail++;
      $display("FAIL full_count: %0d words need %0d",
               hs_cnt - start, NW);
    end
    wait_idle("full");
  endtask

  task automatic test_gap_seq();
    int            t     = 0;
    int            eop_t = -1;
    int            pkts  = 0;
    logic [SW-1:0] last  = '0;
    bit            seen  = 0;
    wr_left = 3 * PL;
    for (int i = 0; i < 400; i++) begin
      step();
      t++;
      if (m_valid && m_sop) begin
        if (eop_t >= 0) begin
          n_chk++;
          if (t - eop_t - 1 != GC + 2) begin
            n_fail++;
            $display("FAIL gap_len: %0d idle cycles need %0d",
                     t - eop_t - 1, GC + 2);
          end
          n_chk++;
          if (m_seq !== last + 8'd1) begin
            n_fail++;
            $display("FAIL gap_seq: seq=%0d need %0d",
                     m_seq, last + 8'd1);
          end
        end
        last = m_seq;
        seen = 1;
      end
      if (seen && m_valid && m_eop) begin
        eop_t = t;
        pkts++;
        if (pkts == 3) break;
      end
    end
    n_chk++;
    if (pkts != 3) begin
      n_fail++;
      $display("FAIL gap_pkts: %0d packets need 3", pkts);
    end
    wait_idle("gap");
  endtask

  task automatic test_flush();
    logic [SW-1:0] pseq = exp_seq_w;
    wr_left = PL;
    wait_sop("fl");
    for (int i = 0; i < 5; i++) step();
    flush = 1'b1;
    #1;
    n_chk++;
    if (fifo_rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL fl_rd: rd=%b in flush cycle need 0", fifo_rd_en);
    end
    step();
    flush = 1'b0;
    n_chk++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || m_seq !== pseq + 8'd1) begin
      n_fail++;
      $display("FAIL fl_after: v=%b busy=%b seq=%0d need 0 0 %0d",
               m_valid, busy, m_seq, pseq + 8'd1);
    end
    clear_fifo();
    exp_seq_w = pseq + 8'd1;
    wr_left   = PL;
    wait_sop("fl_next");
    wait_idle("fl");
  endtask

  task automatic test_underflow();
    bit ok = 0;
    mon_en  = 1'b0;
    flush   = 1'b1;
    wr_left = PL;
    for (int i = 0; i < 40; i++) step();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) step();
    wr_left = 0;
    tb_wr   = 1'b0;
    tb_sclr = 1'b1;
    step();
    tb_sclr = 1'b0;
    n_chk++;
    if (fifo_rd_en !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL uf_stall: rd=%b busy=%b need 0 1",
               fifo_rd_en, busy);
    end
    step();
    n_chk++;
    if (underflow_err !== 1'b1) begin
      n_fail++;
      $display("FAIL uf_flag: underflow_err=%b need 1", underflow_err);
    end
    wr_left = 4;
    for (int i = 0; i < 10; i++) begin
      step();
      if (fifo_rd_en) begin
        ok = 1;
        break;
      end
    end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL uf_resume: rd stayed 0 after refill");
    end
    wr_left = 0;
    flush   = 1'b1;
    step();
    flush = 1'b0;
    clear_fifo();
    n_chk++;
    if (underflow_err !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL uf_sticky: uf=%b busy=%b need 1 0",
               underflow_err, busy);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    wr_left = PL;
    wait_sop("rm");
    for (int i = 0; i < 7; i++) step();
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({fifo_rd_en, m_valid, m_sop, m_eop, m_data, m_seq,
         busy, underflow_err} !== '0) begin
      n_fail++;
      $display("FAIL rm_async: rd=%b v=%b d=%h seq=%0d busy=%b uf=%b need 0",
               fifo_rd_en, m_valid, m_data, m_seq, busy, underflow_err);
    end
    clear_fifo();
    exp_seq_w = '0;
    step();
    rst_n  = 1'b1;
    mon_en = 1'b1;
    wr_left = PL;
    e = '{wr_data, 1'b1, 1'b0, 8'd0};
    wait_sop("rm_next");
    n_chk++;
    if ({m_data, m_sop, m_seq} !== {e.data, e.sop, e.seq}) begin
      n_fail++;
      $display("FAIL rm_first: d=%h sop=%b seq=%0d need %h 1 0",
               m_data, m_sop, m_seq, e.data);
    end
    wait_idle("rm");
  endtask

  task automatic test_seq_wrap();
    int            pkts = 0;
    bit            wrap = 0;
    logic [SW-1:0] prev = '0;
    wr_left = 257 * PL;
    for (int i = 0; i < 8000; i++) begin
      step();
      if (m_valid && m_sop) begin
        if (pkts > 0 && prev == 8'd255 && m_seq == 8'd0) wrap = 1;
        prev = m_seq;
      end
      if (m_valid && m_eop) begin
        pkts++;
        if (pkts == 257) break;
      end
    end
    n_chk++;
    if (pkts != 257 || !wrap) begin
      n_fail++;
      $display("FAIL wrap: pkts=%0d wrap=%b need 257 1", pkts, wrap);
    end
    wait_idle("wrap");
  endtask

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    hs_cnt    = 0;
    wr_left   = 0;
    wr_pos    = 0;
    wr_data   = 32'h0000_0100;
    exp_seq_w = '0;
    tb_wdata  = '0;
    test_reset();
    test_threshold();
    test_backpressure();
    test_full();
    test_gap_seq();
    test_flush();
    test_underflow();
    test_reset_mid();
    test_seq_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
